c3lib_rst_seq: RTL

Reset release sequencer placed directly downstream of c3lib_rstsync. Its rst_n input is the already-synchronized rst_n_sync of the target clock domain. It releases NUM_STAGES staged resets in index order, spaced by a programmable number of cycles, and flags completion. It also supports a software-requested re-reset with a req/ack handshake and a scan-mode bypass.

---
 rtl/c3lib_rst_seq_pkg.sv | 19 +
 rtl/c3lib_rst_seq.sv | 114 +++++++++++
 2 files changed

// File: rtl/c3lib_rst_seq_pkg.sv
// Shared types and helpers for the staged reset release sequencer.
package c3lib_rst_seq_pkg;

    typedef enum logic [2:0] {
        S_HOLD    = 3'd0,
        S_RELEASE = 3'd1,
        S_DONE    = 3'd2,
        S_SWHOLD  = 3'd3,
        S_SWWAIT  = 3'd4
    } rst_seq_state_e;

    // Counter width: max(1, $clog2(dly)).
    function automatic int unsigned cnt_width(input int unsigned dly);
        int unsigned w;
        w = $clog2(dly);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/c3lib_rst_seq.sv
// Releases NUM_STAGES active-low resets in index order, DLY_CYCLES apart, with a
// software re-reset req/ack handshake and a scan-mode bypass on the stage outputs.
module c3lib_rst_seq
    import c3lib_rst_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned DLY_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scan_mode_n,
    input  logic                  rst_n_bypass,
    input  logic                  sw_rst_req,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  seq_done,
    output logic                  sw_rst_ack
);

    localparam int unsigned     CW       = cnt_width(DLY_CYCLES);
    localparam int unsigned     IW       = $clog2(NUM_STAGES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DLY_CYCLES - 1);
    localparam logic [IW-1:0]   IDX_LAST = IW'(NUM_STAGES - 1);

    rst_seq_state_e        state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  done_q, done_d;
    logic                  ack_q, ack_d;
    logic                  cnt_wrap;

    assign cnt_wrap = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            stage_q <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stage_d = stage_q;
        done_d  = done_q;
        ack_d   = ack_q;

        unique case (state_q)
            S_HOLD, S_RELEASE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_wrap) begin
                    cnt_d = '0;
                    idx_d = idx_q + 1'b1;
                    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                        if (idx_q == IW'(i)) begin
                            stage_d[i] = 1'b1;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RELEASE;
                    end
                end
            end
            S_DONE: begin
                if (sw_rst_req) begin
                    stage_d = '0;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_SWHOLD;
                end
            end
            S_SWHOLD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_wrap) begin
                    cnt_d   = '0;
                    ack_d   = 1'b1;
                    state_d = S_SWWAIT;
                end
            end
            S_SWWAIT: begin
                if (!sw_rst_req) begin
                    ack_d   = 1'b0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end
            end
            default: begin
                state_d = S_HOLD;
            end
        endcase
    end

    // Same ternary form as c3lib_rstsync so scan DRC handles both identically.
    assign stage_rst_n = scan_mode_n ? stage_q : {NUM_STAGES{rst_n_bypass}};
    assign seq_done    = done_q;
    assign sw_rst_ack  = ack_q;

endmodule
